// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: synchronizes SCL/SDA, tracks START/STOP,
// matches a fixed 7-bit address, ACKs every accepted byte and strobes out data.
`timescale 1ns/1ps
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   addr_match_q, addr_match_d;
    logic                   frame_done_q, frame_done_d;
    logic                   sda_oe_q, sda_oe_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;

    logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond, byte_end;

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_cond = scl_s & sda_prev_q & ~sda_s;
    assign stop_cond  = scl_s & ~sda_prev_q & sda_s;
    assign byte_end   = scl_rise && (bit_cnt_q == 4'd7);

    // Gated with rst_n so the bus is released the instant reset asserts.
    assign sda = (sda_oe_q && rst_n) ? 1'b0 : 1'bz;

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign addr_match = addr_match_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'd0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            frame_done_q <= 1'b0;
            sda_oe_q     <= 1'b0;
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            frame_done_q <= frame_done_d;
            sda_oe_q     <= sda_oe_d;
            scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_prev_q   <= scl_s;
            sda_prev_q   <= sda_s;
        end
    end

    // Next-state: bus conditions pre-empt any bit or ACK processing.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (stop_cond) begin
            state_d = IDLE;
        end else if (start_cond) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ADDR, DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == DATA)
                                state_d = DATA_ACK;
                            else if (shift_d[7:1] == SLAVE_ADDR && !shift_d[0])
                                state_d = ADDR_ACK;
                            else
                                state_d = IGNORE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // Second falling edge in an ACK state closes the 9th clock.
                    if (scl_fall && sda_oe_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sda_oe_d     = sda_oe_q;
        addr_match_d = addr_match_q;
        rx_valid_d   = 1'b0;
        rx_data_d    = rx_data_q;
        frame_done_d = stop_cond & addr_match_q;
        if (start_cond || stop_cond) begin
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
        end else begin
            if ((state_q == ADDR_ACK || state_q == DATA_ACK) && scl_fall) begin
                sda_oe_d = ~sda_oe_q;
                if (state_q == ADDR_ACK && sda_oe_q)
                    addr_match_d = 1'b1;
            end
            if (state_q == DATA && byte_end) begin
                rx_valid_d = 1'b1;
                rx_data_d  = {shift_q[6:0], sda_s};
            end
        end
    end

endmodule
